// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_pkg
//  Description : Shared writer-class encodings, the tracked-slot record and a
//                saturating countdown helper for the hazard scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_scoreboard_pkg;

  // Writer classes as decoded in EXE
  localparam logic [1:0] CLASS_ALU  = 2'd0;
  localparam logic [1:0] CLASS_LOAD = 2'd1;
  localparam logic [1:0] CLASS_JAL  = 2'd2;
  localparam logic [1:0] CLASS_LONG = 2'd3;

  // Latencies are below DEPTH (at most 8), so three bits always cover them
  localparam int CNT_W = 3;

  typedef struct packed {
    logic             valid;
    logic [4:0]       rd;
    logic [CNT_W-1:0] cnt;
  } slot_t;

  // Ready countdown that holds at zero once the result is forwardable
  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_operand_match.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_operand_match
//  Description : Priority search over tracked slots for one source operand.
//                The youngest (lowest index) matching slot decides: a ready
//                slot yields its forward select, a busy slot raises not_ready.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_operand_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SELW  = 2
) (
  input  slot_t [DEPTH-1:0] slots_i,
  input  logic              valid_i,
  input  logic              use_i,
  input  logic [4:0]        rs_i,
  output logic [SELW-1:0]   sel_o,
  output logic              not_ready_o
);

  // Walk oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    sel_o       = '0;
    not_ready_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_i && use_i && slots_i[i].valid &&
          (slots_i[i].rd != 5'd0) && (slots_i[i].rd == rs_i)) begin
        if (slots_i[i].cnt == '0) begin
          sel_o       = SELW'(i + 1);
          not_ready_o = 1'b0;
        end else begin
          sel_o       = '0;
          not_ready_o = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Tracks in-flight register writers over DEPTH post-EXE slots
//                and produces per-operand forward selects plus a stall when
//                the youngest matching producer is not yet ready.
//                Optional macro HAZARD_SCOREBOARD_PERF_EN adds stall/forward
//                performance counters with a synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int LONG_LAT = 0,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exe_valid,
  input  logic [4:0]      exe_rs1,
  input  logic [4:0]      exe_rs2,
  input  logic            exe_use_rs1,
  input  logic            exe_use_rs2,
  input  logic [4:0]      exe_rd,
  input  logic            exe_we,
  input  logic [1:0]      exe_class,
  input  logic            flush,
  output logic [SELW-1:0] fwd_a_sel,
  output logic [SELW-1:0] fwd_b_sel,
  output logic            stall
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  input  logic            perf_clr,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_fwd_cnt
`endif
);

  if (DEPTH < 1 || DEPTH > 8 || LOAD_LAT >= DEPTH || LONG_LAT >= DEPTH ||
      LOAD_LAT < 0 || LONG_LAT < 0) begin : g_param_check
    $error("hazard_scoreboard: need 1<=DEPTH<=8 and 0<=LOAD_LAT,LONG_LAT<DEPTH");
  end

  slot_t [DEPTH-1:0] slot_q;
  slot_t [DEPTH-1:0] slot_d;
  logic              w_nr_a;
  logic              w_nr_b;
  logic              w_push;
  logic [CNT_W-1:0]  w_push_cnt;

  hazard_operand_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match_a (
    .slots_i     (slot_q),
    .valid_i     (exe_valid),
    .use_i       (exe_use_rs1),
    .rs_i        (exe_rs1),
    .sel_o       (fwd_a_sel),
    .not_ready_o (w_nr_a)
  );

  hazard_operand_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match_b (
    .slots_i     (slot_q),
    .valid_i     (exe_valid),
    .use_i       (exe_use_rs2),
    .rs_i        (exe_rs2),
    .sel_o       (fwd_b_sel),
    .not_ready_o (w_nr_b)
  );

  assign stall  = exe_valid && !flush && (w_nr_a || w_nr_b);
  assign w_push = exe_valid && exe_we && (exe_rd != 5'd0) && !stall && !flush;

  // Initial ready countdown for the writer entering slot 0
  always_comb begin
    w_push_cnt = '0;
    case (exe_class)
      CLASS_LOAD: w_push_cnt = CNT_W'(LOAD_LAT);
      CLASS_LONG: w_push_cnt = CNT_W'(LONG_LAT);
      default:    w_push_cnt = '0;
    endcase
  end

  // Shift slots toward retirement, counting down; slot 0 takes push or bubble
  always_comb begin
    slot_d = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      slot_d[i+1]     = slot_q[i];
      slot_d[i+1].cnt = cnt_dec(slot_q[i].cnt);
    end
    slot_d[0].valid = w_push;
    slot_d[0].rd    = w_push ? exe_rd : 5'd0;
    slot_d[0].cnt   = w_push ? w_push_cnt : '0;
    if (flush) begin
      slot_d = '0;
    end
  end

  // Slot state register; reset dominates flush, push and advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_fwd_q;
  logic        w_fwd_evt;

  assign w_fwd_evt = ((fwd_a_sel != '0) || (fwd_b_sel != '0)) && !stall;

  // Saturating event counters with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      if (stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (w_fwd_evt && (perf_fwd_q != 32'hFFFF_FFFF)) begin
        perf_fwd_q <= perf_fwd_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_fwd_cnt   = perf_fwd_q;
`endif

endmodule
`default_nettype wire
